// File: rtl/axi_sram_slave.sv
//==============================================================================
// Module   : axi_sram_slave
// Purpose  : Single-port AXI4 slave memory model. One outstanding read and one
//            outstanding write, single-beat only, programmable read latency.
//            Read data is returned shifted so the byte at ARADDR sits in
//            RDATA[7:0]; write lanes are taken relative to AWADDR.
// Ports    : clk, rstn (async active-low)
//            AR : ARID, ARADDR, ARLEN, ARVALID -> ARREADY
//            R  : RID, RDATA, RRESP, RLAST, RVALID <- RREADY
//            AW : AWID, AWADDR, AWLEN, AWVALID -> AWREADY
//            W  : WDATA, WSTRB, WLAST (ignored), WVALID -> WREADY
//            B  : BID, BRESP, BVALID <- BREADY
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_sram_slave #(
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter int          MEM_DEPTH = 4096,
    parameter int          RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    // read address
    input  logic [3:0]  ARID,
    input  logic [63:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic        ARVALID,
    output logic        ARREADY,
    // read data
    output logic [3:0]  RID,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY,
    // write address
    input  logic [3:0]  AWID,
    input  logic [63:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic        AWVALID,
    output logic        AWREADY,
    // write data
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    input  logic        WVALID,
    output logic        WREADY,
    // write response
    output logic [3:0]  BID,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY
);

    localparam int          IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES   = 64'(MEM_DEPTH) << 3;
    localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LAT - 1);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    // Decode is address range first, so an out-of-range burst reports DECERR.
    function automatic logic [1:0] decode_resp(input logic [63:0] addr,
                                               input logic [7:0]  len);
        if ((addr < ADDR_BASE) || ((addr - ADDR_BASE) >= MEM_BYTES))
            return RESP_DECERR;
        else if (len != 8'd0)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr);
        return IDX_W'((addr - ADDR_BASE) >> 3);
    endfunction

    // Backing store; deliberately not reset so contents survive rstn.
    logic [63:0] mem_q [MEM_DEPTH];

    logic unused_wlast;
    assign unused_wlast = WLAST;

    //--------------------------------------------------------------------------
    // Read channel
    //--------------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rstate_t;

    rstate_t      rstate_q;
    logic         arready_q;
    logic         rvalid_q;
    logic [3:0]   rid_q;
    logic [3:0]   rcnt_q;
    logic [63:0]  raddr_q;
    logic [1:0]   rerr_q;
    logic [1:0]   rresp_q;
    logic [63:0]  rdata_q;
    logic [IDX_W-1:0] rd_idx_d;

    assign rd_idx_d = word_idx(raddr_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= 4'd0;
            rcnt_q    <= 4'd0;
            raddr_q   <= 64'd0;
            rerr_q    <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 64'd0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    // Also raises ARREADY on the first edge out of reset.
                    arready_q <= 1'b1;
                    if (ARVALID && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= ARID;
                        raddr_q   <= ARADDR;
                        rerr_q    <= decode_resp(ARADDR, ARLEN);
                        rcnt_q    <= RD_CNT_INIT;
                        rstate_q  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == 4'd0) begin
                        // Sampling here means a write committing on this same
                        // edge is not yet visible: read returns old data.
                        if (rerr_q == RESP_OKAY)
                            rdata_q <= mem_q[rd_idx_d] >> {raddr_q[2:0], 3'b000};
                        else
                            rdata_q <= 64'd0;
                        rresp_q  <= rerr_q;
                        rvalid_q <= 1'b1;
                        rstate_q <= R_RESP;
                    end else begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    //--------------------------------------------------------------------------
    // Write channel
    //--------------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wstate_t;

    wstate_t      wstate_q;
    logic         awready_q;
    logic         wready_q;
    logic         bvalid_q;
    logic [3:0]   bid_q;
    logic [1:0]   bresp_q;
    logic [63:0]  awaddr_q;
    logic [3:0]   awid_q;
    logic [1:0]   awerr_q;
    logic [63:0]  wdata_q;
    logic [7:0]   wstrb_q;

    logic         aw_hs_d;
    logic         w_hs_d;
    logic         commit_d;
    logic [63:0]  c_addr_d;
    logic [3:0]   c_id_d;
    logic [1:0]   c_err_d;
    logic [63:0]  c_data_d;
    logic [7:0]   c_strb_d;
    logic [63:0]  lane_mask_d;
    logic [63:0]  wr_mask_d;
    logic [63:0]  wr_data_d;
    logic [IDX_W-1:0] wr_idx_d;

    assign aw_hs_d = AWVALID && awready_q;
    assign w_hs_d  = WVALID && wready_q;

    // The readies already encode the state, so a commit is simply "both
    // halves present", whether held or arriving this cycle.
    assign commit_d = ((wstate_q == W_IDLE)    && aw_hs_d && w_hs_d) ||
                      ((wstate_q == W_HAVE_AW) && w_hs_d) ||
                      ((wstate_q == W_HAVE_W)  && aw_hs_d);

    always_comb begin
        c_addr_d = AWADDR;
        c_id_d   = AWID;
        c_err_d  = decode_resp(AWADDR, AWLEN);
        c_data_d = WDATA;
        c_strb_d = WSTRB;
        if (wstate_q == W_HAVE_AW) begin
            c_addr_d = awaddr_q;
            c_id_d   = awid_q;
            c_err_d  = awerr_q;
        end
        if (wstate_q == W_HAVE_W) begin
            c_data_d = wdata_q;
            c_strb_d = wstrb_q;
        end
    end

    // Shifting the lane mask left by the byte offset drops the lanes that
    // would cross into the next word, so they are discarded for free.
    always_comb begin
        lane_mask_d = 64'd0;
        for (int i = 0; i < 8; i++)
            lane_mask_d[8*i +: 8] = {8{c_strb_d[i]}};
    end

    assign wr_mask_d = lane_mask_d << {c_addr_d[2:0], 3'b000};
    assign wr_data_d = c_data_d    << {c_addr_d[2:0], 3'b000};
    assign wr_idx_d  = word_idx(c_addr_d);

    always_ff @(posedge clk) begin
        if (commit_d && (c_err_d == RESP_OKAY))
            mem_q[wr_idx_d] <= (mem_q[wr_idx_d] & ~wr_mask_d) | (wr_data_d & wr_mask_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= 64'd0;
            awid_q    <= 4'd0;
            awerr_q   <= RESP_OKAY;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs_d && !w_hs_d) begin
                        awready_q <= 1'b0;
                        awaddr_q  <= AWADDR;
                        awid_q    <= AWID;
                        awerr_q   <= decode_resp(AWADDR, AWLEN);
                        wstate_q  <= W_HAVE_AW;
                    end else if (w_hs_d && !aw_hs_d) begin
                        wready_q  <= 1'b0;
                        wdata_q   <= WDATA;
                        wstrb_q   <= WSTRB;
                        wstate_q  <= W_HAVE_W;
                    end
                end
                W_HAVE_AW, W_HAVE_W: ;
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
            // Commit overrides whatever the state branch chose above.
            if (commit_d) begin
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bid_q     <= c_id_d;
                bresp_q   <= c_err_d;
                wstate_q  <= W_RESP;
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;

endmodule

`default_nettype wire
